// File: rtl/alu_arbiter.sv
// alu_arbiter: shares the single integer ALU between a priority port (0) and a
// secondary port (1), with a saturating starvation counter that lets port 1 win.
module alu_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        I_clk,
  input  logic        I_reset,
  input  logic        I_req0_valid,
  input  logic [4:0]  I_req0_op,
  input  logic [31:0] I_req0_s1,
  input  logic [31:0] I_req0_s2,
  input  logic        I_req1_valid,
  input  logic [4:0]  I_req1_op,
  input  logic [31:0] I_req1_s1,
  input  logic [31:0] I_req1_s2,
  output logic        O_req0_ready,
  output logic        O_req1_ready,
  output logic        O_rsp0_valid,
  output logic        O_rsp1_valid,
  output logic [31:0] O_rsp_data,
  output logic        O_rsp_lt,
  output logic        O_rsp_ltu,
  output logic        O_rsp_eq,
  output logic        O_alu_en,
  output logic [4:0]  O_alu_op,
  output logic [31:0] O_alu_s1,
  output logic [31:0] O_alu_s2,
  input  logic        I_alu_busy,
  input  logic [31:0] I_alu_data,
  input  logic        I_alu_lt,
  input  logic        I_alu_ltu,
  input  logic        I_alu_eq
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t        state, next_state;
  logic [CW-1:0] starve_cnt;
  logic [4:0]    hold_op;
  logic [31:0]   hold_s1, hold_s2;
  logic          hold_owner;
  logic          grant_window, starved, grant0, grant1, done;

  // A grant can happen in IDLE or in the WAIT cycle that completes the op.
  always_comb begin
    done         = (state == WAIT) && !I_alu_busy && !I_reset;
    grant_window = !I_reset && ((state == IDLE) || done);
    starved      = (starve_cnt >= CW'(STARVE_LIMIT));
    grant1       = grant_window && I_req1_valid && (starved || !I_req0_valid);
    grant0       = grant_window && I_req0_valid && !grant1;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (grant0 || grant1) next_state = ISSUE;
      ISSUE:   next_state = WAIT;
      WAIT:    if (!I_alu_busy) next_state = (grant0 || grant1) ? ISSUE : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_reset) state <= IDLE;
    else         state <= next_state;
  end

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      hold_op    <= '0;
      hold_s1    <= '0;
      hold_s2    <= '0;
      hold_owner <= 1'b0;
    end else if (grant1) begin
      hold_op    <= I_req1_op;
      hold_s1    <= I_req1_s1;
      hold_s2    <= I_req1_s2;
      hold_owner <= 1'b1;
    end else if (grant0) begin
      hold_op    <= I_req0_op;
      hold_s1    <= I_req0_s1;
      hold_s2    <= I_req0_s2;
      hold_owner <= 1'b0;
    end
  end

  // Saturates at STARVE_LIMIT; only the >= comparison matters beyond that.
  always_ff @(posedge I_clk) begin
    if (I_reset)                          starve_cnt <= '0;
    else if (!I_req1_valid || grant1)     starve_cnt <= '0;
    else if (!starved)                    starve_cnt <= starve_cnt + CW'(1);
  end

  assign O_req0_ready = grant0;
  assign O_req1_ready = grant1;
  assign O_rsp0_valid = done && !hold_owner;
  assign O_rsp1_valid = done && hold_owner;
  assign O_rsp_data   = I_alu_data;
  assign O_rsp_lt     = I_alu_lt;
  assign O_rsp_ltu    = I_alu_ltu;
  assign O_rsp_eq     = I_alu_eq;
  assign O_alu_en     = (state == ISSUE);
  assign O_alu_op     = hold_op;
  assign O_alu_s1     = hold_s1;
  assign O_alu_s2     = hold_s2;

endmodule
